rate_counter_gen: RTL

RATE_COUNTER_GEN -- requirements
Module: rate_counter_gen

---
 rtl/rate_counter_pkg.sv | 13 +
 rtl/rate_divider_n.sv | 25 ++
 rtl/rate_counter_gen.sv | 77 +++++++
 3 files changed

// File: rtl/rate_counter_pkg.sv
// Shared rate-select encodings and default divisor reload values for the rate counter.
package rate_counter_pkg;
  typedef enum logic [1:0] {
    SPD_FULL = 2'b00,
    SPD_1    = 2'b01,
    SPD_2    = 2'b10,
    SPD_3    = 2'b11
  } speed_e;

  localparam int DEF_DIV1 = 499;
  localparam int DEF_DIV2 = 999;
  localparam int DEF_DIV3 = 1999;
endpackage

// File: rtl/rate_divider_n.sv
// Reloadable down-counter; Tick fires while the count sits at zero and nothing blocks it.
module rate_divider_n #(
  parameter int DIV_W = 11
) (
  input  logic             ClockIn,
  input  logic             Reset,
  input  logic             Pause,
  input  logic             Reload,
  input  logic [DIV_W-1:0] D,
  output logic             Tick
);
  logic [DIV_W-1:0] DivCount;

  assign Tick = (DivCount == '0) & ~Pause & ~Reload & ~Reset;

  // D is only sampled on a reload, so a Speed change mid-countdown waits for zero.
  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset)                 DivCount <= '0;
    else if (Reload)           DivCount <= D;
    else if (!Pause) begin
      if (DivCount == '0)      DivCount <= D;
      else                     DivCount <= DivCount - 1'b1;
    end
  end
endmodule

// File: rtl/rate_counter_gen.sv
// Modulo-(CNT_MAX+1) up/down counter stepped by a selectable-rate divider tick.
module rate_counter_gen
  import rate_counter_pkg::*;
#(
  parameter int DIV_W   = 11,
  parameter int CNT_W   = 4,
  parameter int CNT_MAX = 15,
  parameter int DIV1    = DEF_DIV1,
  parameter int DIV2    = DEF_DIV2,
  parameter int DIV3    = DEF_DIV3
) (
  input  logic             ClockIn,
  input  logic             Reset,
  input  logic [1:0]       Speed,
  input  logic             Down,
  input  logic             Pause,
  input  logic             Load,
  input  logic [CNT_W-1:0] LoadValue,
  output logic [CNT_W-1:0] CounterValue,
  output logic             Tick,
  output logic             Wrap
);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(CNT_MAX);

  logic [DIV_W-1:0] divD;

  always_comb begin
    divD = '0;
    case (speed_e'(Speed))
      SPD_FULL: divD = '0;
      SPD_1:    divD = DIV_W'(DIV1);
      SPD_2:    divD = DIV_W'(DIV2);
      SPD_3:    divD = DIV_W'(DIV3);
      default:  divD = '0;
    endcase
  end

  rate_divider_n #(.DIV_W(DIV_W)) uDiv (
    .ClockIn (ClockIn),
    .Reset   (Reset),
    .Pause   (Pause),
    .Reload  (Load),
    .D       (divD),
    .Tick    (Tick)
  );

  // Tick already excludes Pause and Load, so the else branch covers both holds.
  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      CounterValue <= '0;
      Wrap         <= 1'b0;
    end else if (Load) begin
      CounterValue <= (LoadValue > CntMax) ? CntMax : LoadValue;
      Wrap         <= 1'b0;
    end else if (Tick) begin
      if (Down) begin
        if (CounterValue == '0) begin
          CounterValue <= CntMax;
          Wrap         <= 1'b1;
        end else begin
          CounterValue <= CounterValue - 1'b1;
          Wrap         <= 1'b0;
        end
      end else begin
        if (CounterValue == CntMax) begin
          CounterValue <= '0;
          Wrap         <= 1'b1;
        end else begin
          CounterValue <= CounterValue + 1'b1;
          Wrap         <= 1'b0;
        end
      end
    end else begin
      Wrap <= 1'b0;
    end
  end
endmodule
